// File: rtl/ps2_pkg.sv
// Shared scan codes, receiver states and command indices for the PS/2 command path.
// The WASD codes are only consumed when PS2_WASD_EN is defined.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    CMD_UP    = 3'd0,
    CMD_DOWN  = 3'd1,
    CMD_LEFT  = 3'd2,
    CMD_RIGHT = 3'd3,
    CMD_RST   = 3'd4
  } cmd_t;

  localparam int N_CMD = 5;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter, frame FSM and
// mid-frame timeout. Emits a received byte with a one-cycle valid or error pulse.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_filt;
  logic [FW-1:0] r_filt_cnt;

  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_idle_cnt;
  logic [7:0]    r_byte;
  logic          r_valid;
  logic          r_err;

  logic w_flip;
  logic w_strobe;
  logic w_data;
  logic w_timeout;
  logic w_ok;
  logic w_err;

  // The filter flips on the FILTER_LEN-th consecutive differing sample; a 1->0 flip is the strobe.
  assign w_flip    = (r_clk_sync[1] != r_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_strobe  = w_flip && r_filt;
  assign w_data    = r_dat_sync[1];
  assign w_timeout = (r_state != RX_IDLE) && (r_idle_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      if (r_clk_sync[1] == r_filt) begin
        r_filt_cnt <= '0;
      end else if (w_flip) begin
        r_filt_cnt <= '0;
        r_filt     <= ~r_filt;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ok         = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_strobe && !w_data) w_state_next = RX_DATA;
      end
      RX_DATA: begin
        if (w_strobe && (r_bit_cnt == 3'd7)) w_state_next = RX_PARITY;
      end
      RX_PARITY: begin
        if (w_strobe) w_state_next = RX_STOP;
      end
      RX_STOP: begin
        if (w_strobe) begin
          w_state_next = RX_IDLE;
          if (parity_ok(r_shift, r_parity) && w_data) w_ok  = 1'b1;
          else                                         w_err = 1'b1;
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
    if (w_timeout && !w_strobe) begin
      w_state_next = RX_IDLE;
      w_ok         = 1'b0;
      w_err        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_idle_cnt <= '0;
      r_byte     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_ok;
      r_err   <= w_err;
      if (w_ok) r_byte <= r_shift;
      if ((w_state_next == RX_IDLE) || w_strobe) r_idle_cnt <= '0;
      else                                       r_idle_cnt <= r_idle_cnt + TW'(1);
      if (w_strobe) begin
        case (r_state)
          RX_IDLE:   r_bit_cnt <= '0;
          RX_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          RX_PARITY: r_parity <= w_data;
          default: ;
        endcase
      end
    end
  end

  assign o_byte  = r_byte;
  assign o_valid = r_valid;
  assign o_err   = r_err;

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 keyboard front end: receives frames, tracks E0/F0 prefixes and held keys, and
// emits one pulse per key press. Define PS2_WASD_EN to also map the WASD keys.
module ps2_cmd_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_rst
);

`ifdef PS2_WASD_EN
  localparam int N_SLOT = 9;
`else
  localparam int N_SLOT = 5;
`endif

  logic [7:0] w_rx_byte;
  logic       w_rx_valid;
  logic       w_rx_err;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_byte    (w_rx_byte),
    .o_valid   (w_rx_valid),
    .o_err     (w_rx_err)
  );

  logic              r_ext;
  logic              r_brk;
  logic [N_SLOT-1:0] r_held;
  logic [N_CMD-1:0]  r_pulse;

  logic              w_hit;
  cmd_t              w_cmd;
  logic [N_SLOT-1:0] w_slot_oh;
  logic              w_fresh;
  logic              w_prefix;

  // Each mapped (ext, code) pair owns one held-flag slot.
  always_comb begin
    w_hit     = 1'b0;
    w_cmd     = CMD_UP;
    w_slot_oh = '0;
    if (r_ext) begin
      case (w_rx_byte)
        SC_UP:    begin w_hit = 1'b1; w_cmd = CMD_UP;    w_slot_oh[0] = 1'b1; end
        SC_DOWN:  begin w_hit = 1'b1; w_cmd = CMD_DOWN;  w_slot_oh[1] = 1'b1; end
        SC_LEFT:  begin w_hit = 1'b1; w_cmd = CMD_LEFT;  w_slot_oh[2] = 1'b1; end
        SC_RIGHT: begin w_hit = 1'b1; w_cmd = CMD_RIGHT; w_slot_oh[3] = 1'b1; end
        default: ;
      endcase
    end else begin
      case (w_rx_byte)
        SC_ESC:   begin w_hit = 1'b1; w_cmd = CMD_RST;   w_slot_oh[4] = 1'b1; end
`ifdef PS2_WASD_EN
        SC_W:     begin w_hit = 1'b1; w_cmd = CMD_UP;    w_slot_oh[5] = 1'b1; end
        SC_S:     begin w_hit = 1'b1; w_cmd = CMD_DOWN;  w_slot_oh[6] = 1'b1; end
        SC_A:     begin w_hit = 1'b1; w_cmd = CMD_LEFT;  w_slot_oh[7] = 1'b1; end
        SC_D:     begin w_hit = 1'b1; w_cmd = CMD_RIGHT; w_slot_oh[8] = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  assign w_fresh  = |(w_slot_oh & ~r_held);
  assign w_prefix = (w_rx_byte == SC_EXT) || (w_rx_byte == SC_BRK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_held  <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      if (w_rx_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_rx_valid) begin
        if (w_rx_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_rx_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (w_hit && !w_prefix) begin
            if (r_brk) begin
              r_held <= r_held & ~w_slot_oh;
            end else if (w_fresh) begin
              r_held         <= r_held | w_slot_oh;
              r_pulse[w_cmd] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign scan_code  = w_rx_byte;
  assign code_valid = w_rx_valid;
  assign frame_err  = w_rx_err;
  assign key_up     = r_pulse[CMD_UP];
  assign key_down   = r_pulse[CMD_DOWN];
  assign key_left   = r_pulse[CMD_LEFT];
  assign key_right  = r_pulse[CMD_RIGHT];
  assign key_rst    = r_pulse[CMD_RST];

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder: directed scenarios plus random frames,
// compared every cycle against a frame-level behavioural model.
module tb_ps2_cmd_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, frame_err;
  logic       key_up, key_down, key_left, key_right, key_rst;

  ps2_cmd_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_rst(key_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [4:0] cmd;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   hp = 16;
  int   cnt_cmd [5];
  int   cnt_valid = 0;
  int   cnt_err = 0;
  exp_t exp_q[$];
  logic [7:0] exp_scan = 8'h00;
  logic [4:0] pend = 5'b0;
  bit   m_ext, m_brk;
  bit   m_held [512];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Key map from the command table: returns command index or -1.
  function automatic int keymap(input bit ext, input logic [7:0] c);
    if (ext) begin
      if (c == 8'h75) return 0;
      if (c == 8'h72) return 1;
      if (c == 8'h6B) return 2;
      if (c == 8'h74) return 3;
    end else begin
      if (c == 8'h76) return 4;
`ifdef PS2_WASD_EN
      if (c == 8'h1D) return 0;
      if (c == 8'h1B) return 1;
      if (c == 8'h1C) return 2;
      if (c == 8'h23) return 3;
`endif
    end
    return -1;
  endfunction

  function automatic logic [4:0] model_byte(input logic [7:0] b);
    logic [4:0] r;
    int k;
    r = 5'b0;
    if (b == 8'hE0) begin m_ext = 1; return r; end
    if (b == 8'hF0) begin m_brk = 1; return r; end
    k = keymap(m_ext, b);
    if (k >= 0) begin
      if (m_brk) m_held[{m_ext, b}] = 0;
      else if (!m_held[{m_ext, b}]) begin
        m_held[{m_ext, b}] = 1;
        r[k] = 1'b1;
      end
    end
    m_ext = 0;
    m_brk = 0;
    return r;
  endfunction

  task automatic model_reset();
    m_ext = 0;
    m_brk = 0;
    for (int i = 0; i < 512; i++) m_held[i] = 0;
  endtask

  task automatic drive_bit(input logic d, input bit glitch);
    ps2_data = d;
    tick(hp);
    if (glitch) begin
      ps2_clk = 1'b0;
      tick(FILT - 1);
      ps2_clk = 1'b1;
      tick(hp);
    end
    ps2_clk = 1'b0;
    tick(hp);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic [10:0] fr;
    logic        p;
    exp_t        e;
    p  = ~(^b) ^ bad_par;
    fr = {~bad_stop, p, b, 1'b0};
    e.data = b;
    if (bad_par || bad_stop) begin
      e.is_err = 1; e.cmd = 5'b0;
      m_ext = 0; m_brk = 0;
    end else begin
      e.is_err = 0; e.cmd = model_byte(b);
    end
    exp_q.push_back(e);
    for (int i = 0; i < 11; i++) drive_bit(fr[i], glitch && (i == 4));
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic send_partial(input logic [3:0] bits);
    drive_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(bits[i], 0);
    ps2_data = 1'b1;
  endtask

  // Every-cycle comparison against the model's expected event stream.
  initial begin
    exp_t       e;
    logic [4:0] got, nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 5'b0;
        exp_scan = 8'h00;
        continue;
      end
      got = {key_rst, key_right, key_left, key_down, key_up};
      check("cmd_pulse", {27'b0, got}, {27'b0, pend});
      for (int i = 0; i < 5; i++) if (got[i]) cnt_cmd[i]++;
      if (code_valid) cnt_valid++;
      if (frame_err) cnt_err++;
      nxt = 5'b0;
      if (code_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'b0, frame_err, code_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {30'b0, frame_err, code_valid}, {30'b0, e.is_err, !e.is_err});
          if (!e.is_err) begin
            exp_scan = e.data;
            nxt = e.cmd;
          end
        end
      end
      check("scan_code", {24'b0, scan_code}, {24'b0, exp_scan});
      pend = nxt;
    end
  end

  initial begin
    int c0, c1, c2;
    logic [7:0] tbl [12];
    logic [7:0] b;
    tbl = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h76, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h00};
    for (int i = 0; i < 5; i++) cnt_cmd[i] = 0;
    model_reset();

    tick(5);
    check("reset_outputs", {19'b0, scan_code, code_valid, frame_err, key_up, key_down, key_left, key_right, key_rst}, 32'h0);
    rst = 1'b0;
    tick(5);

    // Extended up arrow
    c0 = cnt_valid; c1 = cnt_cmd[0];
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    check("t1_valid_count", cnt_valid - c0, 2);
    check("t1_scan_code", {24'b0, scan_code}, 32'h75);
    check("t1_up_pulses", cnt_cmd[0] - c1, 1);

    // Auto-repeat then release then press again
    c0 = cnt_cmd[2];
    repeat (3) begin send_frame(8'hE0, 0, 0, 0); send_frame(8'h6B, 0, 0, 0); end
    send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h6B, 0, 0, 0);
    check("t2_left_once", cnt_cmd[2] - c0, 1);
    send_frame(8'hE0, 0, 0, 0); send_frame(8'h6B, 0, 0, 0);
    check("t2_left_again", cnt_cmd[2] - c0, 2);

    // Parity error on Esc
    c0 = cnt_err; c1 = cnt_valid; c2 = cnt_cmd[4];
    send_frame(8'h76, 1, 0, 0);
    check("t3_err_count", cnt_err - c0, 1);
    check("t3_no_valid", cnt_valid - c1, 0);
    check("t3_scan_kept", {24'b0, scan_code}, 32'h6B);
    check("t3_no_rst", cnt_cmd[4] - c2, 0);
    send_frame(8'h76, 0, 0, 0);
    check("t3_rst_pulse", cnt_cmd[4] - c2, 1);

    // Mid-frame timeout
    c0 = cnt_err; c1 = cnt_cmd[1];
    begin
      exp_t e;
      e.is_err = 1; e.data = 8'h00; e.cmd = 5'b0;
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
    send_partial(4'b1010);
    tick(TMO + 100);
    check("t4_timeout_err", cnt_err - c0, 1);
    send_frame(8'hE0, 0, 0, 0); send_frame(8'h72, 0, 0, 0);
    check("t4_down_pulse", cnt_cmd[1] - c1, 1);

    // Short glitch on ps2_clk during the data bits
    c0 = cnt_cmd[3]; c1 = cnt_valid;
    send_frame(8'hE0, 0, 0, 1); send_frame(8'h74, 0, 0, 1);
    check("t5_glitch_valid", cnt_valid - c1, 2);
    check("t5_right_pulse", cnt_cmd[3] - c0, 1);
    check("t5_scan_code", {24'b0, scan_code}, 32'h74);

    // Reset in the middle of a frame
    c0 = cnt_err; c1 = cnt_cmd[4]; c2 = cnt_cmd[0];
    send_partial(4'b0110);
    rst = 1'b1;
    tick(2);
    check("t6_reset_outputs", {19'b0, scan_code, code_valid, frame_err, key_up, key_down, key_left, key_right, key_rst}, 32'h0);
    model_reset();
    rst = 1'b0;
    tick(TMO + 100);
    check("t6_no_err", cnt_err - c0, 0);
    send_frame(8'h76, 0, 0, 0);
    check("t6_rst_pulse", cnt_cmd[4] - c1, 1);
    send_frame(8'h1D, 0, 0, 0);
`ifdef PS2_WASD_EN
    check("t6_wasd_up", cnt_cmd[0] - c2, 1);
`else
    check("t6_wasd_up", cnt_cmd[0] - c2, 0);
`endif

    // Random frames
    for (int n = 0; n < 60; n++) begin
      int  sel;
      bit  bp, bs;
      hp  = $urandom_range(12, 20);
      sel = $urandom_range(0, 11);
      b   = (sel == 11) ? 8'($urandom) : tbl[sel];
      bp  = ($urandom_range(0, 9) == 0);
      bs  = !bp && ($urandom_range(0, 11) == 0);
      send_frame(b, bp, bs, 0);
      tick($urandom_range(0, 30));
    end

    tick(50);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
